// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: next-PC select codes,
// FSM states and the instruction alignment mask.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JALR   = 3'd2,
    SRC_RET    = 3'd3,
    SRC_TRAP   = 3'd4
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// occupancy count, so a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop,
  output logic [WIDTH-1:0] top_addr,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = RAS_DEPTH[PW:0];

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW:0]      cnt;

  // Push+pop together swaps the top entry in place, leaving pointer and count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop) begin
      mem[ptr] <= push_addr;
    end else if (push) begin
      mem[ptr + 1'b1] <= push_addr;
      ptr             <= ptr + 1'b1;
      if (cnt != FULL_CNT) cnt <= cnt + 1'b1;
    end else if (pop) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  assign top_addr = mem[ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt FSM selecting the next fetch
// address from sequential, branch, jalr, return-stack and trap sources.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  pc_src_e          pc_src,
  input  logic [WIDTH-1:0] base_pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] jalr_base,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_addr,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic             ras_empty,
  output logic             ras_full,
  output pc_state_e        state
);

  logic [WIDTH-1:0] nxt_pc;
  logic [WIDTH-1:0] redirect_tgt;
  logic [WIDTH-1:0] ras_top;
  pc_state_e        nxt_state;
  logic             nxt_mis;
  logic             ras_pop;
  logic             ras_push_en;
  logic             is_redirect;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_en),
    .push_addr (ras_push_addr),
    .pop       (ras_pop),
    .top_addr  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc_plus4     = pc + WIDTH'(4);
  assign is_redirect  = (pc_src == SRC_BRANCH) || (pc_src == SRC_JALR);
  assign redirect_tgt = (pc_src == SRC_JALR)
                      ? ((jalr_base + imm) & ~WIDTH'(1))
                      : (base_pc + imm);
  assign fetch_valid  = (state == ST_RUN) && !stall;

  // Priority in RUN: trap, branch/jalr, return, halt/stall hold, sequential.
  always_comb begin
    nxt_pc      = pc;
    nxt_state   = state;
    nxt_mis     = 1'b0;
    ras_pop     = 1'b0;
    ras_push_en = 1'b0;
    case (state)
      ST_BOOT: begin
        nxt_pc    = RESET_VECTOR;
        nxt_state = ST_RUN;
      end
      ST_RUN: begin
        ras_push_en = ras_push && !stall;
        if (pc_src == SRC_TRAP) begin
          nxt_pc = trap_vec;
        end else if (is_redirect) begin
          if ((redirect_tgt[1:0] & ALIGN_MASK) != 2'b00) begin
            nxt_pc  = trap_vec;
            nxt_mis = 1'b1;
          end else begin
            nxt_pc = redirect_tgt;
          end
        end else if ((pc_src == SRC_RET) && !ras_empty) begin
          nxt_pc  = ras_top;
          ras_pop = 1'b1;
        end else if (halt) begin
          nxt_state = ST_HALT;
        end else if (!stall) begin
          nxt_pc = pc_plus4;
        end
      end
      ST_HALT: begin
        if (pc_src == SRC_TRAP) begin
          nxt_pc    = trap_vec;
          nxt_state = ST_RUN;
        end else if (resume) begin
          nxt_state = ST_RUN;
        end
      end
      default: begin
        nxt_pc    = RESET_VECTOR;
        nxt_state = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      state      <= nxt_state;
      pc         <= nxt_pc;
      misaligned <= nxt_mis;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: boot sequence, redirects,
// misalignment traps, return-stack behaviour, halt/resume and mid-run reset.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  pc_src_e     pc_src;
  logic [31:0] base_pc, imm, jalr_base, trap_vec, ras_push_addr;
  logic        ras_push, halt, resume;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, misaligned, ras_empty, ras_full;
  pc_state_e   state;

  int check_count = 0;
  int pass_count  = 0;

  pc_gen #(.WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .base_pc       (base_pc),
    .imm           (imm),
    .jalr_base     (jalr_base),
    .trap_vec      (trap_vec),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .misaligned    (misaligned),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .state         (state)
  );

  always #5 clk = ~clk;

  // One clock: inputs already set, outputs sampled 1ns after the edge.
  task automatic applyStimulus(input pc_src_e src, input logic push, input logic [31:0] paddr);
    pc_src        = src;
    ras_push      = push;
    ras_push_addr = paddr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = SRC_SEQ;
    base_pc = '0; imm = '0; jalr_base = '0; trap_vec = 32'h400;
    ras_push = 1'b0; ras_push_addr = '0; halt = 1'b0; resume = 1'b0;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("rst_state", 32'(state), 32'(ST_BOOT));
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_fv", 32'(fetch_valid), 32'd0);
    checkOutput("rst_mis", 32'(misaligned), 32'd0);
    checkOutput("rst_empty", 32'(ras_empty), 32'd1);
    checkOutput("rst_full", 32'(ras_full), 32'd0);

    rst = 1'b0;
    checkOutput("boot_state", 32'(state), 32'(ST_BOOT));
    checkOutput("boot_fv", 32'(fetch_valid), 32'd0);
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("run_state", 32'(state), 32'(ST_RUN));
    checkOutput("run_pc0", pc, 32'h0);
    checkOutput("run_fv", 32'(fetch_valid), 32'd1);
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("seq_pc4", pc, 32'h4);

    base_pc = 32'h0; imm = 32'h100;
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    checkOutput("branch_fwd", pc, 32'h100);

    base_pc = 32'h100; imm = 32'hFFFF_FFF0; stall = 1'b1; pc_src = SRC_BRANCH;
    #1 checkOutput("stall_fv", 32'(fetch_valid), 32'd0);
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    checkOutput("branch_stall", pc, 32'hF0);
    stall = 1'b0;

    jalr_base = 32'h203; imm = 32'h0;
    applyStimulus(SRC_JALR, 1'b0, 32'h0);
    checkOutput("jalr_mis_pc", pc, 32'h400);
    checkOutput("jalr_mis_flag", 32'(misaligned), 32'd1);
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("mis_pulse_end", 32'(misaligned), 32'd0);
    checkOutput("after_trap_seq", pc, 32'h404);

    jalr_base = 32'h205; imm = 32'hFFFF_FFFC;
    applyStimulus(SRC_JALR, 1'b0, 32'h0);
    checkOutput("jalr_ok", pc, 32'h200);
    checkOutput("jalr_ok_mis", 32'(misaligned), 32'd0);

    base_pc = 32'hFFFF_FFFC; imm = 32'h8;
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    checkOutput("branch_wrap", pc, 32'h4);

    stall = 1'b1;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("stall_hold", pc, 32'h4);
    stall = 1'b0;
    applyStimulus(pc_src_e'(3'd7), 1'b0, 32'h0);
    checkOutput("unused_src", pc, 32'h8);

    for (int k = 1; k <= 5; k++) applyStimulus(SRC_SEQ, 1'b1, 32'(k * 16));
    checkOutput("push5_pc", pc, 32'h1C);
    checkOutput("push5_full", 32'(ras_full), 32'd1);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("ret1", pc, 32'h50);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("ret2", pc, 32'h40);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("ret3", pc, 32'h30);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("ret4", pc, 32'h20);
    checkOutput("ret4_empty", 32'(ras_empty), 32'd1);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("ret_empty_seq", pc, 32'h24);

    applyStimulus(SRC_SEQ, 1'b1, 32'h30);
    applyStimulus(SRC_SEQ, 1'b1, 32'h40);
    applyStimulus(SRC_RET, 1'b1, 32'h80);
    checkOutput("pushret_pc", pc, 32'h40);
    checkOutput("pushret_empty", 32'(ras_empty), 32'd0);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("pushret_top", pc, 32'h80);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("pushret_next", pc, 32'h30);
    checkOutput("pushret_cnt", 32'(ras_empty), 32'd1);

    applyStimulus(SRC_TRAP, 1'b1, 32'h90);
    checkOutput("trap_push_pc", pc, 32'h400);
    applyStimulus(SRC_RET, 1'b0, 32'h0);
    checkOutput("trap_push_ret", pc, 32'h90);

    base_pc = 32'h40; imm = 32'h0;
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    halt = 1'b1;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("halt_state", 32'(state), 32'(ST_HALT));
    checkOutput("halt_pc", pc, 32'h40);
    checkOutput("halt_fv", 32'(fetch_valid), 32'd0);
    halt = 1'b0;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("halt_hold", pc, 32'h40);
    resume = 1'b1; trap_vec = 32'h800;
    applyStimulus(SRC_TRAP, 1'b0, 32'h0);
    checkOutput("halt_trap_state", 32'(state), 32'(ST_RUN));
    checkOutput("halt_trap_pc", pc, 32'h800);
    resume = 1'b0;

    halt = 1'b1; base_pc = 32'h100;
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    checkOutput("halt_redir_state", 32'(state), 32'(ST_RUN));
    checkOutput("halt_redir_pc", pc, 32'h100);
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("halt_late_state", 32'(state), 32'(ST_HALT));
    halt = 1'b0; resume = 1'b1;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("resume_pc", pc, 32'h100);
    resume = 1'b0;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("resume_seq", pc, 32'h104);
    checkOutput("pc_plus4", pc_plus4, 32'h108);

    applyStimulus(SRC_SEQ, 1'b1, 32'h60);
    checkOutput("pre_rst_empty", 32'(ras_empty), 32'd0);
    halt = 1'b1;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    halt = 1'b0; rst = 1'b1; base_pc = 32'h300;
    applyStimulus(SRC_BRANCH, 1'b0, 32'h0);
    checkOutput("midrst_state", 32'(state), 32'(ST_BOOT));
    checkOutput("midrst_pc", pc, 32'h0);
    checkOutput("midrst_empty", 32'(ras_empty), 32'd1);
    rst = 1'b0;
    applyStimulus(SRC_SEQ, 1'b0, 32'h0);
    checkOutput("midrst_run", 32'(state), 32'(ST_RUN));
    checkOutput("midrst_run_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
